// File: rtl/char_bbox_frame_ctrl_if.sv
// Result channel from the bounding-box frame sequencer to the crop/scale stage.
// The pix_cnt_o field exists only when BBOX_PIXCNT_EN is defined.
interface char_bbox_frame_ctrl_if;
   logic        bbox_valid;
   logic        bbox_ready;
   logic        bbox_empty;
   logic [12:0] x_min_o;
   logic [12:0] x_max_o;
   logic [12:0] y_min_o;
   logic [12:0] y_max_o;
   logic [7:0]  drop_cnt;
`ifdef BBOX_PIXCNT_EN
   logic [19:0] pix_cnt_o;

   modport master (
      output bbox_valid, bbox_empty, x_min_o, x_max_o, y_min_o, y_max_o, drop_cnt, pix_cnt_o,
      input  bbox_ready
   );
   modport slave (
      input  bbox_valid, bbox_empty, x_min_o, x_max_o, y_min_o, y_max_o, drop_cnt, pix_cnt_o,
      output bbox_ready
   );
`else
   modport master (
      output bbox_valid, bbox_empty, x_min_o, x_max_o, y_min_o, y_max_o, drop_cnt,
      input  bbox_ready
   );
   modport slave (
      input  bbox_valid, bbox_empty, x_min_o, x_max_o, y_min_o, y_max_o, drop_cnt,
      output bbox_ready
   );
`endif
endinterface

// File: rtl/char_bbox_frame_ctrl.sv
// Frame sequencer for the character bounding-box accumulator: pixel coordinates, per-frame
// clear/snapshot of the box and valid/ready delivery. Optional pixel counter: BBOX_PIXCNT_EN.
module char_bbox_frame_ctrl #(
   parameter int H_ACTIVE = 1280,
   parameter int V_ACTIVE = 720
`ifdef BBOX_PIXCNT_EN
   ,
   parameter int MIN_PIX  = 64
`endif
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          VSync,
   input  logic                          HSync,
   input  logic                          VDE,
   input  logic                          Y,
   output logic [10:0]                   x_num,
   output logic [9:0]                    y_num,
   output logic                          bbox_clr,
   input  logic [12:0]                   x_min_i,
   input  logic [12:0]                   x_max_i,
   input  logic [12:0]                   y_min_i,
   input  logic [12:0]                   y_max_i,
   char_bbox_frame_ctrl_if.master        bbox_if
);
   localparam logic [10:0] X_LAST = 11'(H_ACTIVE - 1);
   localparam logic [9:0]  Y_LAST = 10'(V_ACTIVE - 1);

   typedef enum logic [1:0] {
      WAIT_SOF = 2'd0,
      ACTIVE   = 2'd1,
      SETTLE   = 2'd2,
      CAPTURE  = 2'd3
   } state_e;

   state_e      state_q;
   logic        vsync_q;
   logic        vde_q;
   logic [10:0] x_num_q;
   logic [10:0] x_num_d;
   logic [9:0]  y_num_q;
   logic [9:0]  y_num_d;
   logic        bbox_clr_q;
   logic        valid_q;
   logic        empty_q;
   logic [12:0] x_min_q;
   logic [12:0] x_max_q;
   logic [12:0] y_min_q;
   logic [12:0] y_max_q;
   logic [7:0]  drop_cnt_q;

   logic        sof_s;
   logic        eof_s;
   logic        vde_fall_s;
   logic        pix_act_s;
   logic        order_empty_s;
   logic        empty_d_s;
   logic        latch_s;

   assign sof_s         = vsync_q & ~VSync;
   assign eof_s         = ~vsync_q & VSync;
   assign vde_fall_s    = vde_q & ~VDE;
   assign pix_act_s     = ~VSync & HSync & VDE;
   assign order_empty_s = (x_min_i > x_max_i) | (y_min_i > y_max_i);
   // A new box may overwrite the held one only if the slot is free or being emptied now.
   assign latch_s       = (state_q == CAPTURE) & (~valid_q | bbox_if.bbox_ready);

   // Next-state for the pixel coordinate counters.
   always_comb begin
      x_num_d = x_num_q;
      y_num_d = y_num_q;
      if (sof_s) begin
         x_num_d = 11'd0;
         y_num_d = 10'd0;
      end else if (vde_fall_s) begin
         x_num_d = 11'd0;
         if (y_num_q != Y_LAST) begin
            y_num_d = y_num_q + 10'd1;
         end else begin
            y_num_d = y_num_q;
         end
      end else if (pix_act_s && (x_num_q != X_LAST)) begin
         x_num_d = x_num_q + 11'd1;
      end else begin
         x_num_d = x_num_q;
      end
   end

   // Sync edge history and coordinate registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vsync_q <= 1'b0;
         vde_q   <= 1'b0;
         x_num_q <= 11'd0;
         y_num_q <= 10'd0;
      end else begin
         vsync_q <= VSync;
         vde_q   <= VDE;
         x_num_q <= x_num_d;
         y_num_q <= y_num_d;
      end
   end

   // Frame FSM with the clear pulse, held result and handshake state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= WAIT_SOF;
         bbox_clr_q <= 1'b0;
         valid_q    <= 1'b0;
         empty_q    <= 1'b0;
         x_min_q    <= 13'd0;
         x_max_q    <= 13'd0;
         y_min_q    <= 13'd0;
         y_max_q    <= 13'd0;
         drop_cnt_q <= 8'd0;
      end else begin
         bbox_clr_q <= sof_s;
         if (valid_q && bbox_if.bbox_ready) begin
            valid_q <= 1'b0;
         end
         case (state_q)
            WAIT_SOF: begin
               if (sof_s) begin
                  state_q <= ACTIVE;
               end
            end
            ACTIVE: begin
               if (eof_s) begin
                  state_q <= SETTLE;
               end
            end
            SETTLE: begin
               state_q <= CAPTURE;
            end
            CAPTURE: begin
               if (latch_s) begin
                  x_min_q <= x_min_i;
                  x_max_q <= x_max_i;
                  y_min_q <= y_min_i;
                  y_max_q <= y_max_i;
                  empty_q <= empty_d_s;
                  valid_q <= 1'b1;
               end else if (drop_cnt_q != 8'hFF) begin
                  drop_cnt_q <= drop_cnt_q + 8'd1;
               end
               state_q <= WAIT_SOF;
            end
            default: begin
               state_q <= WAIT_SOF;
            end
         endcase
      end
   end

`ifdef BBOX_PIXCNT_EN
   localparam logic [19:0] MIN_PIX_W = 20'(MIN_PIX);

   logic [19:0] pix_cnt_q;
   logic [19:0] pix_snap_q;

   assign empty_d_s = order_empty_s | (pix_cnt_q < MIN_PIX_W);

   // Foreground pixel counter for the current frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pix_cnt_q <= 20'd0;
      end else if (sof_s) begin
         pix_cnt_q <= 20'd0;
      end else if (pix_act_s && Y && (pix_cnt_q != 20'hFFFFF)) begin
         pix_cnt_q <= pix_cnt_q + 20'd1;
      end
   end

   // Count snapshot taken together with the box.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pix_snap_q <= 20'd0;
      end else if (latch_s) begin
         pix_snap_q <= pix_cnt_q;
      end
   end

   assign bbox_if.pix_cnt_o = pix_snap_q;
`else
   logic unused_y_s;

   assign unused_y_s = Y;
   assign empty_d_s  = order_empty_s;
`endif

   assign x_num              = x_num_q;
   assign y_num              = y_num_q;
   assign bbox_clr           = bbox_clr_q;
   assign bbox_if.bbox_valid = valid_q;
   assign bbox_if.bbox_empty = empty_q;
   assign bbox_if.x_min_o    = x_min_q;
   assign bbox_if.x_max_o    = x_max_q;
   assign bbox_if.y_min_o    = y_min_q;
   assign bbox_if.y_max_o    = y_max_q;
   assign bbox_if.drop_cnt   = drop_cnt_q;
endmodule

// File: tb/tb_char_bbox_frame_ctrl.sv
// Self-checking bench for char_bbox_frame_ctrl: random frames against a frame-level box model,
// plus an external min/max accumulator model driven by the DUT coordinates and clear pulse.
module tb_char_bbox_frame_ctrl;
   localparam int H_ACTIVE = 1280;
   localparam int V_ACTIVE = 720;
`ifdef BBOX_PIXCNT_EN
   localparam int MIN_PIX  = 64;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        VSync, HSync, VDE, Y;
   logic [10:0] x_num;
   logic [9:0]  y_num;
   logic        bbox_clr;
   logic [12:0] acc_xmin = 13'h1FFF, acc_xmax = 13'd0, acc_ymin = 13'h1FFF, acc_ymax = 13'd0;

   int n_tests = 0;
   int n_fail  = 0;
   int clr_cnt = 0;

   // Frame-level model: box of the frame being driven, and the result held downstream.
   int f_xmin, f_xmax, f_ymin, f_ymax, f_cnt, f_row;
   int h_xmin, h_xmax, h_ymin, h_ymax, h_cnt, h_empty;
   int exp_drop;
   bit exp_valid;

   char_bbox_frame_ctrl_if bbox_if ();

   char_bbox_frame_ctrl #(.H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .VSync   (VSync),
      .HSync   (HSync),
      .VDE     (VDE),
      .Y       (Y),
      .x_num   (x_num),
      .y_num   (y_num),
      .bbox_clr(bbox_clr),
      .x_min_i (acc_xmin),
      .x_max_i (acc_xmax),
      .y_min_i (acc_ymin),
      .y_max_i (acc_ymax),
      .bbox_if (bbox_if)
   );

   always #5 clk = ~clk;

   // Downstream accumulator: one-cycle update latency, reloaded by bbox_clr.
   always @(posedge clk) begin
      if (bbox_clr) begin
         acc_xmin <= 13'h1FFF;
         acc_xmax <= 13'd0;
         acc_ymin <= 13'h1FFF;
         acc_ymax <= 13'd0;
      end else if (!VSync && HSync && VDE && Y) begin
         if ({2'b00, x_num} < acc_xmin) acc_xmin <= {2'b00, x_num};
         if ({2'b00, x_num} > acc_xmax) acc_xmax <= {2'b00, x_num};
         if ({3'b000, y_num} < acc_ymin) acc_ymin <= {3'b000, y_num};
         if ({3'b000, y_num} > acc_ymax) acc_ymax <= {3'b000, y_num};
      end
   end

   always @(negedge clk) begin
      if (bbox_clr) clr_cnt <= clr_cnt + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_zero_outputs(input string tag);
      check_eq({tag, "_x"}, x_num, 0);
      check_eq({tag, "_y"}, y_num, 0);
      check_eq({tag, "_clr"}, bbox_clr, 0);
      check_eq({tag, "_valid"}, bbox_if.bbox_valid, 0);
      check_eq({tag, "_empty"}, bbox_if.bbox_empty, 0);
      check_eq({tag, "_xmin"}, bbox_if.x_min_o, 0);
      check_eq({tag, "_xmax"}, bbox_if.x_max_o, 0);
      check_eq({tag, "_ymin"}, bbox_if.y_min_o, 0);
      check_eq({tag, "_ymax"}, bbox_if.y_max_o, 0);
      check_eq({tag, "_drop"}, bbox_if.drop_cnt, 0);
`ifdef BBOX_PIXCNT_EN
      check_eq({tag, "_pix"}, bbox_if.pix_cnt_o, 0);
`endif
   endtask

   task automatic frame_start();
      int clr0;
      clr0  = clr_cnt;
      VSync = 1'b0; HSync = 1'b0; VDE = 1'b0; Y = 1'($urandom_range(0, 1));
      step();
      check_eq("sof_clr_hi", bbox_clr, 1);
      check_eq("sof_x0", x_num, 0);
      check_eq("sof_y0", y_num, 0);
      step();
      check_eq("sof_clr_lo", bbox_clr, 0);
      repeat (2) step();
      check_eq("sof_clr_once", clr_cnt - clr0, 1);
      f_xmin = 8191; f_xmax = 0; f_ymin = 8191; f_ymax = 0; f_cnt = 0; f_row = 0;
   endtask

   // One line of w pixels; fg with probability pct%, plus a forced fg at column fg_col.
   task automatic drive_line(input int w, input int pct, input int fg_col);
      int xs, ys;
      ys = (f_row > V_ACTIVE - 1) ? V_ACTIVE - 1 : f_row;
      for (int i = 0; i < w; i++) begin
         xs = (i > H_ACTIVE - 1) ? H_ACTIVE - 1 : i;
         if (i == 0) begin
            check_eq("line_x0", x_num, 0);
            check_eq("line_y", y_num, ys);
         end
         if (i == w - 1) check_eq("line_xlast", x_num, xs);
         HSync = 1'b1; VDE = 1'b1;
         Y = (i == fg_col) || (int'($urandom_range(0, 99)) < pct);
         if (Y) begin
            f_cnt++;
            if (xs < f_xmin) f_xmin = xs;
            if (xs > f_xmax) f_xmax = xs;
            if (ys < f_ymin) f_ymin = ys;
            if (ys > f_ymax) f_ymax = ys;
         end
         step();
      end
      HSync = 1'b0; VDE = 1'b0; Y = 1'($urandom_range(0, 1));
      repeat (3) step();
      f_row++;
   endtask

   function automatic int frame_empty();
      int e;
      e = (f_xmin > f_xmax) || (f_ymin > f_ymax);
`ifdef BBOX_PIXCNT_EN
      if (f_cnt < MIN_PIX) e = 1;
`endif
      return e;
   endfunction

   task automatic frame_end();
      bit rdy;
      rdy   = bbox_if.bbox_ready;
      VSync = 1'b1; HSync = 1'b0; VDE = 1'b0; Y = 1'($urandom_range(0, 1));
      step();
      step();
      if (!exp_valid) check_eq("eof_lat2_valid", bbox_if.bbox_valid, 0);
      step();
      if (!exp_valid) begin
         h_xmin = f_xmin; h_xmax = f_xmax; h_ymin = f_ymin; h_ymax = f_ymax;
         h_cnt = f_cnt; h_empty = frame_empty();
         exp_valid = 1'b1;
      end else if (exp_drop < 255) begin
         exp_drop++;
      end
      check_eq("eof_lat3_valid", bbox_if.bbox_valid, 1);
      check_eq("box_xmin", bbox_if.x_min_o, h_xmin);
      check_eq("box_xmax", bbox_if.x_max_o, h_xmax);
      check_eq("box_ymin", bbox_if.y_min_o, h_ymin);
      check_eq("box_ymax", bbox_if.y_max_o, h_ymax);
      check_eq("box_empty", bbox_if.bbox_empty, h_empty);
      check_eq("drop_cnt", bbox_if.drop_cnt, exp_drop);
`ifdef BBOX_PIXCNT_EN
      check_eq("pix_cnt", bbox_if.pix_cnt_o, h_cnt);
`endif
      if (rdy) begin
         step();
         exp_valid = 1'b0;
         check_eq("accept_valid_clr", bbox_if.bbox_valid, 0);
      end
      repeat (3) step();
   endtask

   initial begin
      rst_n = 1'b0; VSync = 1'b1; HSync = 1'b0; VDE = 1'b0; Y = 1'b0;
      bbox_if.bbox_ready = 1'b1;
      exp_valid = 1'b0; exp_drop = 0;
      h_xmin = 0; h_xmax = 0; h_ymin = 0; h_ymax = 0; h_cnt = 0; h_empty = 0;
      repeat (3) step();
      check_zero_outputs("reset");
      rst_n = 1'b1;
      repeat (3) step();
      check_eq("no_clr_before_sof", clr_cnt, 0);

      // Single fg pixel at (2,1) in a 4x4 frame.
      frame_start();
      drive_line(4, 0, -1);
      drive_line(4, 0, 2);
      drive_line(4, 0, -1);
      drive_line(4, 0, -1);
      frame_end();
      check_eq("t1_clr_total", clr_cnt, 1);

      // No foreground at all.
      frame_start();
      repeat (3) drive_line(6, 0, -1);
      frame_end();

      // Random frames with ready held high.
      for (int k = 0; k < 6; k++) begin
         int w, h, pct;
         w = $urandom_range(3, 24); h = $urandom_range(1, 6); pct = $urandom_range(0, 60);
         frame_start();
         for (int r = 0; r < h; r++) drive_line(w, pct, -1);
         frame_end();
      end

      // Downstream stalled across three frames.
      bbox_if.bbox_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         frame_start();
         for (int r = 0; r < 3; r++) drive_line(5 + k, 40, k);
         frame_end();
      end
      check_eq("t3_drop2", bbox_if.drop_cnt, 2);
      check_eq("t3_held_valid", bbox_if.bbox_valid, 1);
      bbox_if.bbox_ready = 1'b1;
      step();
      exp_valid = 1'b0;
      check_eq("t3_release_valid", bbox_if.bbox_valid, 0);
      check_eq("t3_release_xmin", bbox_if.x_min_o, h_xmin);

      // Mid-line reset at x_num=37 with a result held downstream.
      bbox_if.bbox_ready = 1'b0;
      frame_start();
      drive_line(8, 50, 3);
      frame_end();
      frame_start();
      for (int i = 0; i < 60; i++) begin
         HSync = 1'b1; VDE = 1'b1; Y = 1'($urandom_range(0, 1));
         if (i == 37) begin
            check_eq("t4_x37", x_num, 37);
            #1 rst_n = 1'b0;
            #1;
            check_zero_outputs("t4_rst");
            bbox_if.bbox_ready = 1'b1;
            exp_valid = 1'b0; exp_drop = 0;
            h_xmin = 0; h_xmax = 0; h_ymin = 0; h_ymax = 0; h_cnt = 0; h_empty = 0;
         end
         if (i == 39) #2 rst_n = 1'b1;
         step();
      end
      HSync = 1'b0; VDE = 1'b0; Y = 1'b0;
      repeat (3) step();
      VSync = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         check_eq("t4_no_valid", bbox_if.bbox_valid, 0);
      end
      frame_start();
      drive_line(7, 0, 4);
      drive_line(7, 30, -1);
      frame_end();

      // Over-long line saturates x_num; the next line restarts at 0.
      frame_start();
      drive_line(1300, 0, 1299);
      drive_line(5, 0, -1);
      frame_end();

`ifdef BBOX_PIXCNT_EN
      // Pixel-count qualification around MIN_PIX.
      frame_start();
      drive_line(10, 100, -1);
      frame_end();
      frame_start();
      repeat (5) drive_line(20, 100, -1);
      frame_end();
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
